// File: rtl/bram_access_arbiter.sv
// Two-requester arbiter (Wishbone firmware / accelerator) in front of a single-port BRAM.
// Define BRAM_ARB_WB_PRIO_EN for fixed WB priority; default is round-robin.
module bram_access_arbiter #(
    parameter int unsigned DELAYS    = 10,
    parameter logic [31:0] ADDR_MASK = 32'h0000_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        acc_req_i,
    input  logic        acc_we_i,
    input  logic [3:0]  acc_sel_i,
    input  logic [31:0] acc_adr_i,
    input  logic [31:0] acc_dat_i,
    output logic        acc_gnt_o,
    output logic        acc_rvalid_o,
    output logic [31:0] acc_dat_o,
    output logic        bram_en_o,
    output logic [3:0]  bram_we_o,
    output logic [31:0] bram_adr_o,
    output logic [31:0] bram_dat_o,
    input  logic [31:0] bram_dat_i,
    output logic        busy_o
);

    localparam int unsigned CNT_W     = (DELAYS > 1) ? $clog2(DELAYS) : 1;
    localparam int unsigned CNT_LAST  = (DELAYS > 0) ? DELAYS - 1 : 0;
    localparam bit          HAS_WAIT  = (DELAYS != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic        owner_acc;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } cmd_t;

    state_t           state;
    state_t           state_nxt;
    cmd_t             cmd;
    logic [CNT_W-1:0] cnt;
    logic             wb_req;
    logic             grant;
    logic             pick_acc;

    assign wb_req = wbs_cyc_i & wbs_stb_i;
    assign grant  = (state == S_IDLE) & (wb_req | acc_req_i);

    // Owner selection on a tie: fixed WB priority or alternate away from the last owner.
`ifdef BRAM_ARB_WB_PRIO_EN
    assign pick_acc = acc_req_i & ~wb_req;
`else
    logic last_acc;

    assign pick_acc = acc_req_i & (~wb_req | ~last_acc);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            last_acc <= 1'b1;
        end else if (grant) begin
            last_acc <= pick_acc;
        end
    end
`endif

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_nxt = HAS_WAIT ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!cmd.owner_acc && !wbs_cyc_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_W'(CNT_LAST)) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Command latch and wait counter
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cmd <= '0;
            cnt <= '0;
        end else begin
            if (grant) begin
                cmd.owner_acc <= pick_acc;
                cmd.we        <= pick_acc ? acc_we_i  : wbs_we_i;
                cmd.sel       <= pick_acc ? acc_sel_i : wbs_sel_i;
                cmd.adr       <= pick_acc ? acc_adr_i : wbs_adr_i;
                cmd.dat       <= pick_acc ? acc_dat_i : wbs_dat_i;
            end
            if ((state == S_WAIT) && (state_nxt == S_WAIT)) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // Output decode; read data is passed straight through from the BRAM register
    always_comb begin
        wbs_ack_o    = 1'b0;
        wbs_dat_o    = '0;
        acc_gnt_o    = 1'b0;
        acc_rvalid_o = 1'b0;
        acc_dat_o    = '0;
        bram_en_o    = 1'b0;
        bram_we_o    = '0;
        busy_o       = 1'b0;
        bram_adr_o   = cmd.adr & ADDR_MASK;
        bram_dat_o   = cmd.dat;
        case (state)
            S_IDLE: begin
                acc_gnt_o = grant & pick_acc & wb_rst_n;
            end
            S_WAIT: begin
                busy_o = 1'b1;
            end
            S_ACCESS: begin
                busy_o    = 1'b1;
                bram_en_o = 1'b1;
                bram_we_o = cmd.sel & {4{cmd.we}};
            end
            S_RESP: begin
                busy_o    = 1'b1;
                bram_en_o = 1'b1;
                if (cmd.owner_acc) begin
                    acc_rvalid_o = 1'b1;
                    acc_dat_o    = bram_dat_i;
                end else begin
                    wbs_ack_o = wbs_cyc_i;
                    wbs_dat_o = bram_dat_i;
                end
            end
            default: ;
        endcase
    end

endmodule
